// File: rtl/dec_pkg.sv
// -----------------------------------------------------------------------------
// dec_pkg
// Shared constants and types for the 5-to-32 row/word-line select decoder.
//   DEC_IN_W  : width of the binary index
//   DEC_OUT_W : width of the one-hot select vector (2**DEC_IN_W)
//   sel_t     : one-hot select vector type used by array periphery consumers
// -----------------------------------------------------------------------------
package dec_pkg;

  localparam int DEC_IN_W  = 5;
  localparam int DEC_OUT_W = 32;

  typedef logic [DEC_OUT_W-1:0] sel_t;

endpackage : dec_pkg

// File: rtl/onehot_dec.sv
// -----------------------------------------------------------------------------
// onehot_dec
// Purely combinational, enable-gated binary-to-one-hot decoder.
//   en  : decode enable; 0 forces all select lines low
//   din : binary index
//   sel : one-hot select (bit din set when en=1), all-zero when en=0
// -----------------------------------------------------------------------------
module onehot_dec #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 32
) (
  input  logic             en,
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] sel
);

  always_comb begin
    // NOTE: default assignment first so every path drives sel; no latch is inferred.
    sel = '0;
    if (en) begin
      sel = OUT_W'(1) << din;
    end
  end

endmodule : onehot_dec

// File: rtl/decoder_5to32.sv
// -----------------------------------------------------------------------------
// decoder_5to32
// Registered 5-to-32 one-hot decoder with enable. One clock of latency; the
// select lines come straight from flops so they are glitch-free.
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset, clears dout and dout_valid
//   en         : decode enable; 0 drives all select lines inactive
//   din        : binary index to decode
//   dout       : registered one-hot select, active-high
//   dout_valid : registered copy of en; 1 when dout holds a decoded value
// -----------------------------------------------------------------------------
module decoder_5to32
  import dec_pkg::*;
#(
  parameter int IN_W  = DEC_IN_W,
  parameter int OUT_W = DEC_OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid
);

  // A full decode needs exactly one output line per index value.
  if (OUT_W != (1 << IN_W)) begin : g_bad_width
    $fatal(1, "decoder_5to32: OUT_W (%0d) must equal 2**IN_W (%0d)", OUT_W, 1 << IN_W);
  end

  logic [OUT_W-1:0] sel_next;

  onehot_dec #(
    .IN_W (IN_W),
    .OUT_W(OUT_W)
  ) u_onehot_dec (
    .en (en),
    .din(din),
    .sel(sel_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout       <= sel_next;
      dout_valid <= en;
    end
  end

  // Index must be fully known whenever a decode is requested.
  a_din_known: assert property (@(posedge clk) disable iff (!rst_n)
    en |-> !$isunknown(din))
    else $error("decoder_5to32: X/Z on din while en=1");

  // Never more than one select line active.
  a_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(dout))
    else $error("decoder_5to32: dout not one-hot/zero: %h", dout);

  // A line is active exactly when the output is marked valid.
  a_valid_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    (dout != '0) == dout_valid)
    else $error("decoder_5to32: dout/dout_valid disagree: %h/%b", dout, dout_valid);

endmodule : decoder_5to32

// File: tb/tb_decoder_5to32.sv
// -----------------------------------------------------------------------------
// tb_decoder_5to32
// Directed self-checking bench for decoder_5to32. Inputs change 1 ns after a
// rising edge and outputs are sampled 1 ns after the following rising edge.
// -----------------------------------------------------------------------------
module tb_decoder_5to32;
  import dec_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [4:0] din;
  sel_t       dout;
  logic       dout_valid;

  int total = 0;
  int bad   = 0;

  decoder_5to32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .din       (din),
    .dout      (dout),
    .dout_valid(dout_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Apply inputs, let one rising edge capture them, sample just after it.
  task automatic step(input logic e, input logic [4:0] d);
    en  = e;
    din = d;
    @(posedge clk);
    #1;
  endtask

  logic [4:0]  nm_din [8];
  logic [31:0] nm_exp [8];

  initial begin
    nm_din = '{5'd18, 5'd19, 5'd20, 5'd21, 5'd18, 5'd19, 5'd20, 5'd21};
    nm_exp = '{32'h0004_0000, 32'h0008_0000, 32'h0010_0000, 32'h0020_0000,
               32'h0004_0000, 32'h0008_0000, 32'h0010_0000, 32'h0020_0000};

    // Reset, asserted before any clock edge.
    rst_n = 1'b0;
    en    = 1'b0;
    din   = 5'd0;
    #2;
    check("reset_dout",  dout,       32'h0);
    check("reset_valid", {31'h0, dout_valid}, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Enable low for two cycles.
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 5'd0);
      check("idle_dout",  dout, 32'h0);
      check("idle_valid", {31'h0, dout_valid}, 32'h0);
    end

    // Boundary: lowest index.
    step(1'b1, 5'd0);
    check("din0_dout",  dout, 32'h0000_0001);
    check("din0_valid", {31'h0, dout_valid}, 32'h1);

    // Sweep 1..31.
    for (int i = 1; i < 32; i++) begin
      step(1'b1, 5'(i));
      check("sweep_dout",   dout, 32'h1 << i);
      check("sweep_onehot", {31'h0, $onehot(dout)}, 32'h1);
      check("sweep_valid",  {31'h0, dout_valid}, 32'h1);
      if (i == 21) check("din21_dout", dout, 32'h0020_0000);
      if (i == 31) check("din31_dout", dout, 32'h8000_0000);
    end

    // Non-monotonic / repeated indices decode independently.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, nm_din[i]);
      check("nonmono_dout", dout, nm_exp[i]);
    end

    // Drop enable with din=31: all lines inactive.
    step(1'b1, 5'd31);
    check("pre_drop_dout", dout, 32'h8000_0000);
    step(1'b0, 5'd31);
    check("en_off_dout",  dout, 32'h0);
    check("en_off_valid", {31'h0, dout_valid}, 32'h0);

    // Enable and index change on the same edge.
    step(1'b1, 5'd5);
    check("en_on_dout",  dout, 32'h0000_0020);
    check("en_on_valid", {31'h0, dout_valid}, 32'h1);

    // Mid-cycle asynchronous reset while dout=0x400.
    step(1'b1, 5'd10);
    check("pre_rst_dout", dout, 32'h0000_0400);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_dout",  dout, 32'h0);
    check("async_rst_valid", {31'h0, dout_valid}, 32'h0);
    en  = 1'b1;
    din = 5'd3;
    @(posedge clk);
    #1;
    check("held_rst_dout", dout, 32'h0);
    #2;
    rst_n = 1'b1;

    // First edge after release decodes current en/din.
    @(posedge clk);
    #1;
    check("post_rst_dout",  dout, 32'h0000_0008);
    check("post_rst_valid", {31'h0, dout_valid}, 32'h1);

    step(1'b0, 5'd3);
    check("final_off_dout", dout, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_decoder_5to32
